// File: rtl/io_mmio.sv
// io_mmio: memory-mapped data RAM plus GPIO_CH GPIO channels on the Yduck data bus.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   din       - write data
//   addr      - word address
//   we        - 1 = write this cycle, 0 = read this cycle
//   dout      - registered read data, held while we=1
//   gpio_in   - asynchronous channel inputs, channel c at [c*DW +: DW]
//   gpio_out  - channel output registers, same packing
//   irq       - OR over all channels of (IFG & IE)
//
// Address map: RAM at 0 .. 2**RAM_AW-1; channel c register k at IO_BASE + 4c + k
// (k: 0 IN, 1 OUT, 2 IE, 3 IFG with write-1-to-clear). Everything else reads 0.
//
// Optional feature macro: IO_IRQ_EN. When undefined, no edge-history, IE or IFG
// flops exist, IE/IFG read as 0 and irq is tied low.
module io_mmio #(
  parameter int DW      = 16,
  parameter int AW      = 13,
  parameter int RAM_AW  = 7,
  parameter int GPIO_CH = 2,
  parameter int IO_BASE = 16'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         din,
  input  logic [AW-1:0]         addr,
  input  logic                  we,
  output logic [DW-1:0]         dout,
  input  logic [GPIO_CH*DW-1:0] gpio_in,
  output logic [GPIO_CH*DW-1:0] gpio_out,
  output logic                  irq
);

  localparam int RAM_DEPTH = 2 ** RAM_AW;
  localparam int GW        = GPIO_CH * DW;
  // Compares are done one bit wider so an I/O window ending exactly at 2**AW does not wrap.
  localparam logic [AW:0] RAM_END = (AW+1)'(RAM_DEPTH);
  localparam logic [AW:0] IO_LO   = (AW+1)'(IO_BASE);
  localparam logic [AW:0] IO_HI   = (AW+1)'(IO_BASE + 4 * GPIO_CH);

  logic [DW-1:0]      mem [RAM_DEPTH];
  logic [GW-1:0]      s1_q, s2_q;
  logic [GW-1:0]      out_q, out_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic [DW-1:0]      io_rdata_s, ch_rd_s;
  logic               ram_sel_s, io_sel_s;
  logic [AW:0]        io_off_s;
  logic [1:0]         reg_k_s;
  int                 ch_s;
  logic [GPIO_CH-1:0] hit_s;

`ifdef IO_IRQ_EN
  logic [GW-1:0] s3_q;
  logic [GW-1:0] ie_q, ie_d;
  logic [GW-1:0] ifg_q, ifg_d;
  logic [GW-1:0] rise_s;
  logic [DW-1:0] clr_s;
`endif

  // Address decode: RAM window, I/O window, channel index and register index
  always_comb begin
    ram_sel_s = ({1'b0, addr} < RAM_END);
    io_sel_s  = ({1'b0, addr} >= IO_LO) && ({1'b0, addr} < IO_HI);
    io_off_s  = {1'b0, addr} - IO_LO;
    reg_k_s   = io_off_s[1:0];
    ch_s      = int'(io_off_s[AW:2]);
    hit_s     = '0;
    for (int c = 0; c < GPIO_CH; c++) begin
      hit_s[c] = io_sel_s && (ch_s == c);
    end
  end

  // Per-channel register writes, interrupt flag update and read mux
  always_comb begin
    out_d      = out_q;
    io_rdata_s = '0;
    ch_rd_s    = '0;
`ifdef IO_IRQ_EN
    ie_d   = ie_q;
    ifg_d  = ifg_q;
    rise_s = s2_q & ~s3_q;
    clr_s  = '0;
`endif
    for (int c = 0; c < GPIO_CH; c++) begin
      out_d[c*DW +: DW] = (we && hit_s[c] && (reg_k_s == 2'd1)) ? din : out_q[c*DW +: DW];
`ifdef IO_IRQ_EN
      ie_d[c*DW +: DW]  = (we && hit_s[c] && (reg_k_s == 2'd2)) ? din : ie_q[c*DW +: DW];
      clr_s             = (we && hit_s[c] && (reg_k_s == 2'd3)) ? din : {DW{1'b0}};
      // A rising edge in the same cycle as a W1C clear keeps the flag set.
      ifg_d[c*DW +: DW] = (ifg_q[c*DW +: DW] & ~clr_s) | rise_s[c*DW +: DW];
`endif
      case (reg_k_s)
        2'd0:    ch_rd_s = s2_q[c*DW +: DW];
        2'd1:    ch_rd_s = out_q[c*DW +: DW];
`ifdef IO_IRQ_EN
        2'd2:    ch_rd_s = ie_q[c*DW +: DW];
        2'd3:    ch_rd_s = ifg_q[c*DW +: DW];
`endif
        default: ch_rd_s = {DW{1'b0}};
      endcase
      io_rdata_s = io_rdata_s | (hit_s[c] ? ch_rd_s : {DW{1'b0}});
    end
  end

  // Read data: hold during writes, otherwise capture RAM or I/O value (0 if unmapped)
  always_comb begin
    if (we) begin
      dout_d = dout_q;
    end else if (ram_sel_s) begin
      dout_d = mem[addr[RAM_AW-1:0]];
    end else begin
      dout_d = io_rdata_s;
    end
  end

  // Synchroniser, output registers and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      out_q  <= '0;
      dout_q <= '0;
    end else begin
      s1_q   <= gpio_in;
      s2_q   <= s1_q;
      out_q  <= out_d;
      dout_q <= dout_d;
    end
  end

`ifdef IO_IRQ_EN
  // Edge-history flop and interrupt enable/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q  <= '0;
      ie_q  <= '0;
      ifg_q <= '0;
    end else begin
      s3_q  <= s2_q;
      ie_q  <= ie_d;
      ifg_q <= ifg_d;
    end
  end

  assign irq = |(ifg_q & ie_q);
`else
  assign irq = 1'b0;
`endif

  // RAM write port; contents are deliberately not reset, and reset blocks writes
  always_ff @(posedge clk) begin
    if (!rst && we && ram_sel_s) begin
      mem[addr[RAM_AW-1:0]] <= din;
    end
  end

  assign dout     = dout_q;
  assign gpio_out = out_q;

endmodule

// File: doc/io_mmio.md
# io_mmio

Parametrised memory-mapped I/O block for the Yduck data bus: a small data RAM plus `GPIO_CH` independent DW-bit GPIO channels, each with synchronised inputs, registered outputs and rising-edge interrupt flags. It is the successor to the single-port GPIO/RAM data-space block and sits on the core's data bus (din/addr/we/dout), with one combined `irq` line to the core.

## Interface
- `DW`, 16: data width and GPIO channel width.
- `AW`, 13: data-bus address width.
- `RAM_AW`, 7: RAM address width; RAM depth is 2**RAM_AW words.
- `GPIO_CH`, 2: number of GPIO channels, 1..16.
- `IO_BASE`, 16'h100: first I/O address. Requires IO_BASE + 4*GPIO_CH <= 2**AW and IO_BASE >= 2**RAM_AW.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in DW: write data.
- `addr` in AW: word address.
- `we` in 1: high = write this cycle; low = read this cycle.
- `dout` out DW: registered read data.
- `gpio_in` in GPIO_CH*DW: asynchronous inputs; channel c = bits [c*DW +: DW].
- `gpio_out` out GPIO_CH*DW: output registers, same packing.
- `irq` out 1: OR over all channels of (IFG & IE).

## Operation
- Address map:
  - addr < 2**RAM_AW: RAM word addr[RAM_AW-1:0].
  - IO_BASE + 4c + k, c < GPIO_CH: channel c register k.
    - k=0 IN: RO, synchronised input.
    - k=1 OUT: RW, drives gpio_out.
    - k=2 IE: RW, per-bit interrupt enable.
    - k=3 IFG: rising-edge flags; reads the flags; a write clears each bit where din=1 (W1C).
  - Any other address: reads 0, writes ignored. There is no aliasing.
- Inputs: each channel passes through a 2-flop synchroniser (s1, s2) plus a history flop s3. IN returns s2. A rising edge on a bit is s2 & ~s3.
- IFG update per bit: next = (IFG & ~clr) | rise, where clr is the W1C write mask. When a set and a clear hit the same bit in the same cycle, the set wins.
- RAM contents are not reset.
- Reset clears: OUT, IE, IFG, s1, s2, s3 and dout. gpio_out = 0 and irq = 0.
- After reset, an input held high produces a rising edge and sets the IFG bit. irq stays low unless IE is set.

## Timing
- Write: the target register or RAM word updates at the rising edge where we=1. gpio_out changes in the same edge.
- Read: when we=0 at edge N, dout holds the addressed value from edge N until the next read. Latency is 1 cycle.
- When we=1, dout holds its previous value; there is no read-during-write.
- A read of OUT, IE or IFG in the cycle after a write returns the new value.
- gpio_in change before edge k:
  - IN reads the new value from edge k+1 onward, so a read issued at k+2 sees it.
  - The IFG bit is set at edge k+2.
  - irq (combinational from registers) rises after edge k+2 if enabled.
- irq falls in the cycle after the W1C write edge, or after an IE clear.
- rst asserted mid-operation takes priority over any write in that cycle.

## Configuration
- `IO_IRQ_EN` defined:
  - The edge detector, the IE and IFG registers and `irq` are all implemented as above.
- `IO_IRQ_EN` not defined:
  - No s3, IE or IFG flops are built.
  - IE and IFG addresses read 0 and ignore writes.
  - `irq` is tied to 0.
  - IN and OUT behaviour is unchanged.

## Test plan
- Reset: hold rst 2 cycles with gpio_in=0 -> gpio_out=0, dout=0, irq=0. Then write 0x1234 to RAM 0x05 and read 0x05 -> dout=0x1234 one cycle after the read.
- OUT and IN path: write 0xA5A5 to IO_BASE+5 (ch1 OUT) -> gpio_out[31:16]=0xA5A5 after that edge, and a readback returns 0xA5A5. Set gpio_in[15:0]=0x00FF; a read of IO_BASE+0 issued 2 cycles later -> 0x00FF.
- Interrupt: IE0=0x0001, pulse gpio_in[0] 0->1 -> IFG0=0x0001 and irq=1 at edge+2. W1C 0x0001 to IFG0 -> irq=0 next cycle. A falling edge -> no flag.
- Simultaneous set and clear: with IFG0 bit 3 set, write 0x0008 to IFG0 on the same edge a new rising edge arrives on bit 3 -> bit 3 stays 1.
- Unmapped and boundary addresses:
  - Read IO_BASE+4*GPIO_CH -> 0.
  - Write 0xFFFF to 0x080 -> RAM word 0 unchanged.
  - Write 0xBEEF to 2**RAM_AW-1, then read it -> 0xBEEF.
- Configuration: build without IO_IRQ_EN, write 0xFFFF to IE0 and toggle gpio_in -> IE0 and IFG0 read 0 and irq stays 0.
